// File: rtl/cp0_unit.sv
// MIPS-style coprocessor-0 register file: exception state, EPC/BadVAddr capture,
// Count/Compare timer and registered interrupt request generation.
module cp0_unit #(
   parameter int unsigned EXT_INT_W = 6,
   parameter int unsigned COUNT_DIV = 2,
   parameter bit          BEV_RESET = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb_ex,
   input  logic                 wb_bd,
   input  logic                 ws_eret,
   input  logic [4:0]           wb_excode,
   input  logic [31:0]          wb_pc,
   input  logic [31:0]          wb_badvaddr,
   input  logic [EXT_INT_W-1:0] ext_int_in,
   input  logic                 we_i,
   input  logic [7:0]           addr_i,
   input  logic [31:0]          wdata_i,
   output logic [31:0]          rdata_o,
   output logic                 int_req,
   output logic [31:0]          cp0_status,
   output logic [31:0]          cp0_cause,
   output logic [31:0]          cp0_epc
);

   localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   localparam logic [7:0] ADDR_BADVADDR = 8'h40;
   localparam logic [7:0] ADDR_COUNT    = 8'h48;
   localparam logic [7:0] ADDR_COMPARE  = 8'h58;
   localparam logic [7:0] ADDR_STATUS   = 8'h60;
   localparam logic [7:0] ADDR_CAUSE    = 8'h68;
   localparam logic [7:0] ADDR_EPC      = 8'h70;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;

   logic [7:0]       im_q;
   logic             exl_q;
   logic             ie_q;
   logic             bd_q;
   logic             ti_q;
   logic [1:0]       ip_sw_q;
   logic [4:0]       ip_hw_q;
   logic             ip7_q;
   logic [4:0]       excode_q;
   logic [31:0]      epc_q;
   logic [31:0]      badvaddr_q;
   logic [31:0]      count_q;
   logic [31:0]      compare_q;
   logic [DIV_W-1:0] div_cnt_q;

   logic             wr_count_c;
   logic             wr_compare_c;
   logic             wr_status_c;
   logic             wr_cause_c;
   logic             wr_epc_c;
   logic             tick_c;
   logic [31:0]      count_inc_c;
   logic             ti_set_c;
   logic [5:0]       ext_pad_c;
   logic [7:0]       ip_c;
   logic             first_ex_c;
   logic [31:0]      status_c;
   logic [31:0]      cause_c;

   assign wr_count_c   = we_i && (addr_i == ADDR_COUNT);
   assign wr_compare_c = we_i && (addr_i == ADDR_COMPARE);
   assign wr_status_c  = we_i && (addr_i == ADDR_STATUS);
   assign wr_cause_c   = we_i && (addr_i == ADDR_CAUSE);
   assign wr_epc_c     = we_i && (addr_i == ADDR_EPC);

   assign tick_c      = (div_cnt_q == DIV_LAST);
   assign count_inc_c = count_q + 32'd1;
   assign ti_set_c    = tick_c && !wr_count_c && (count_inc_c == compare_q);

   // Zero-extension makes absent interrupt lines (and IP[7]'s ext share) read 0
   assign ext_pad_c  = 6'(ext_int_in);
   assign ip_c       = {ip7_q, ip_hw_q, ip_sw_q};
   assign first_ex_c = wb_ex && !exl_q;

   assign status_c = {9'b0, 1'(BEV_RESET), 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_c  = {bd_q, ti_q, 14'b0, ip_c, 1'b0, excode_q, 2'b0};

   assign cp0_status = status_c;
   assign cp0_cause  = cause_c;
   assign cp0_epc    = epc_q;

   // MFC0 read port: reflects current register state, so an MTC0 cycle reads the old value
   always_comb begin
      rdata_o = 32'b0;
      case (addr_i)
         ADDR_BADVADDR: rdata_o = badvaddr_q;
         ADDR_COUNT:    rdata_o = count_q;
         ADDR_COMPARE:  rdata_o = compare_q;
         ADDR_STATUS:   rdata_o = status_c;
         ADDR_CAUSE:    rdata_o = cause_c;
         ADDR_EPC:      rdata_o = epc_q;
         default:       rdata_o = 32'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q       <= 8'b0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_sw_q    <= 2'b0;
         ip_hw_q    <= 5'b0;
         ip7_q      <= 1'b0;
         excode_q   <= 5'b0;
         epc_q      <= 32'b0;
         badvaddr_q <= 32'b0;
         count_q    <= 32'b0;
         compare_q  <= 32'hFFFF_FFFF;
         div_cnt_q  <= '0;
         int_req    <= 1'b0;
      end else begin
         // Timer: software load restarts the prescaler and suppresses that cycle's tick
         if (wr_count_c) begin
            count_q   <= wdata_i;
            div_cnt_q <= '0;
         end else if (tick_c) begin
            count_q   <= count_inc_c;
            div_cnt_q <= '0;
         end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
         end

         if (wr_compare_c) begin
            compare_q <= wdata_i;
            ti_q      <= 1'b0;
         end else if (ti_set_c) begin
            ti_q <= 1'b1;
         end

         if (wr_status_c) begin
            im_q <= wdata_i[15:8];
            ie_q <= wdata_i[0];
         end

         if (wb_ex)
            exl_q <= 1'b1;
         else if (ws_eret)
            exl_q <= 1'b0;
         else if (wr_status_c)
            exl_q <= wdata_i[1];

         if (wb_ex) begin
            excode_q <= wb_excode;
            if ((wb_excode == EXC_ADEL) || (wb_excode == EXC_ADES))
               badvaddr_q <= wb_badvaddr;
         end

         // Nested exceptions keep the original restart point and slot flag
         if (first_ex_c) begin
            bd_q  <= wb_bd;
            epc_q <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
         end else if (wr_epc_c) begin
            epc_q <= wdata_i;
         end

         if (wr_cause_c)
            ip_sw_q <= wdata_i[9:8];

         ip_hw_q <= ext_pad_c[4:0];
         ip7_q   <= ti_q | ext_pad_c[5];

         int_req <= ie_q & ~exl_q & (|(ip_c & im_q));
      end
   end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: default instance plus a COUNT_DIV=1 instance for timer-match cases.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_ex;
   logic        wb_bd;
   logic        ws_eret;
   logic [4:0]  wb_excode;
   logic [31:0] wb_pc;
   logic [31:0] wb_badvaddr;
   logic [5:0]  ext_int_in;
   logic        we_i;
   logic [7:0]  addr_i;
   logic [31:0] wdata_i;

   logic [31:0] rdata_o, cp0_status, cp0_cause, cp0_epc;
   logic        int_req;
   logic [31:0] rdata1, status1, cause1, epc1;
   logic        int_req1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cp0_unit u_dut (
      .clk(clk), .reset(reset), .wb_ex(wb_ex), .wb_bd(wb_bd), .ws_eret(ws_eret),
      .wb_excode(wb_excode), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
      .ext_int_in(ext_int_in), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .rdata_o(rdata_o), .int_req(int_req), .cp0_status(cp0_status),
      .cp0_cause(cp0_cause), .cp0_epc(cp0_epc)
   );

   cp0_unit #(.COUNT_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .wb_ex(wb_ex), .wb_bd(wb_bd), .ws_eret(ws_eret),
      .wb_excode(wb_excode), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
      .ext_int_in(ext_int_in), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .rdata_o(rdata1), .int_req(int_req1), .cp0_status(status1),
      .cp0_cause(cause1), .cp0_epc(epc1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
      addr_i = a;
      #1;
      chk(tag, rdata_o, exp);
   endtask

   task automatic rd1_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
      addr_i = a;
      #1;
      chk(tag, rdata1, exp);
   endtask

   task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
      we_i    = 1'b1;
      addr_i  = a;
      wdata_i = d;
      tick();
      we_i    = 1'b0;
   endtask

   task automatic raise_ex(input logic bd, input logic [4:0] code, input logic [31:0] pc,
                           input logic [31:0] bva, input logic eret);
      wb_ex       = 1'b1;
      wb_bd       = bd;
      wb_excode   = code;
      wb_pc       = pc;
      wb_badvaddr = bva;
      ws_eret     = eret;
      tick();
      wb_ex   = 1'b0;
      wb_bd   = 1'b0;
      ws_eret = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wb_ex = 1'b0; wb_bd = 1'b0; ws_eret = 1'b0; wb_excode = 5'd0;
      wb_pc = 32'd0; wb_badvaddr = 32'd0; ext_int_in = 6'd0; we_i = 1'b0;
      addr_i = 8'd0; wdata_i = 32'd0;
      tick();
      tick();

      // Reset state
      chk("rst_status", cp0_status, 32'h0040_0000);
      chk("rst_cause", cp0_cause, 32'h0);
      chk("rst_epc", cp0_epc, 32'h0);
      chk("rst_int_req", 32'(int_req), 32'h0);
      rd_chk("rst_count", 8'h48, 32'h0);
      rd_chk("rst_compare", 8'h58, 32'hFFFF_FFFF);
      rd_chk("rst_badvaddr", 8'h40, 32'h0);
      reset = 1'b0;

      // External interrupt path and EXL masking
      mtc0(8'h60, 32'h0000_0401);
      chk("sts_write", cp0_status, 32'h0040_0401);
      ext_int_in = 6'd1;
      tick();
      chk("ip2_set", cp0_cause, 32'h0000_0400);
      chk("intreq_lag", 32'(int_req), 32'h0);
      tick();
      chk("intreq_on", 32'(int_req), 32'h1);
      raise_ex(1'b0, 5'd0, 32'h0000_0100, 32'h0, 1'b0);
      chk("exl_set", cp0_status, 32'h0040_0403);
      chk("intreq_still", 32'(int_req), 32'h1);
      chk("epc_int", cp0_epc, 32'h0000_0100);
      tick();
      chk("intreq_exl_off", 32'(int_req), 32'h0);
      ws_eret = 1'b1;
      tick();
      ws_eret = 1'b0;
      chk("eret_clr", cp0_status, 32'h0040_0401);
      chk("intreq_eret_lag", 32'(int_req), 32'h0);
      tick();
      chk("intreq_eret_on", 32'(int_req), 32'h1);
      ext_int_in = 6'd0;
      tick();
      chk("ip2_clr", cp0_cause, 32'h0);
      chk("intreq_hold", 32'(int_req), 32'h1);
      tick();
      chk("intreq_drop", 32'(int_req), 32'h0);
      mtc0(8'h60, 32'h0);

      // Delay-slot exception with address error, then nested exception
      raise_ex(1'b1, 5'h04, 32'hBFC0_0104, 32'h0000_1003, 1'b0);
      chk("bd_epc", cp0_epc, 32'hBFC0_0100);
      chk("bd_cause", cp0_cause, 32'h8000_0010);
      chk("bd_status", cp0_status, 32'h0040_0002);
      rd_chk("badva_cap", 8'h40, 32'h0000_1003);
      raise_ex(1'b0, 5'h0C, 32'h0000_0200, 32'h0000_2000, 1'b0);
      chk("nest_epc", cp0_epc, 32'hBFC0_0100);
      chk("nest_cause", cp0_cause, 32'h8000_0030);
      rd_chk("nest_badva", 8'h40, 32'h0000_1003);

      // MTC0 side effects
      mtc0(8'h70, 32'h0000_1234);
      chk("epc_mtc0", cp0_epc, 32'h0000_1234);
      we_i = 1'b1; addr_i = 8'h70; wdata_i = 32'h0000_5555;
      #1;
      chk("prewrite_rd", rdata_o, 32'h0000_1234);
      tick();
      we_i = 1'b0;
      chk("epc_mtc0_b", cp0_epc, 32'h0000_5555);
      mtc0(8'h40, 32'hDEAD_BEEF);
      rd_chk("badva_ro", 8'h40, 32'h0000_1003);
      mtc0(8'h08, 32'hFFFF_FFFF);
      rd_chk("unmapped_rd", 8'h08, 32'h0);
      mtc0(8'h68, 32'hFFFF_FFFF);
      chk("cause_sw_ip", cp0_cause, 32'h8000_0330);
      mtc0(8'h68, 32'h0);
      chk("cause_sw_clr", cp0_cause, 32'h8000_0030);

      // Simultaneous exception and ERET
      ws_eret = 1'b1;
      tick();
      ws_eret = 1'b0;
      raise_ex(1'b0, 5'd0, 32'h0000_0300, 32'h0, 1'b1);
      chk("ex_eret_exl", cp0_status, 32'h0040_0002);
      chk("ex_eret_epc", cp0_epc, 32'h0000_0300);

      // Count wrap with COUNT_DIV=2
      mtc0(8'h48, 32'hFFFF_FFFE);
      rd_chk("cnt_load", 8'h48, 32'hFFFF_FFFE);
      tick();
      rd_chk("cnt_hold", 8'h48, 32'hFFFF_FFFE);
      tick();
      rd_chk("cnt_ffff", 8'h48, 32'hFFFF_FFFF);
      tick();
      tick();
      rd_chk("cnt_wrap", 8'h48, 32'h0);

      // Compare match with COUNT_DIV=1
      mtc0(8'h58, 32'd10);
      mtc0(8'h48, 32'd8);
      rd1_chk("t_cnt8", 8'h48, 32'd8);
      chk("t_ti0", 32'(cause1[30]), 32'h0);
      tick();
      rd1_chk("t_cnt9", 8'h48, 32'd9);
      tick();
      rd1_chk("t_cnt10", 8'h48, 32'd10);
      chk("t_ti_set", 32'(cause1[30]), 32'h1);
      chk("t_ip7_lag", 32'(cause1[15]), 32'h0);
      tick();
      chk("t_ip7_set", 32'(cause1[15]), 32'h1);
      mtc0(8'h48, 32'd9);
      chk("t_ti_kept", 32'(cause1[30]), 32'h1);
      mtc0(8'h58, 32'd50);
      chk("t_cmp_wins", 32'(cause1[30]), 32'h0);
      rd1_chk("t_cmp_new", 8'h58, 32'd50);
      rd1_chk("t_cnt_match", 8'h48, 32'd10);

      // Reset during a pending interrupt with concurrent events
      mtc0(8'h60, 32'h0000_0401);
      ext_int_in = 6'd1;
      tick();
      tick();
      chk("pre_rst_int", 32'(int_req), 32'h1);
      reset = 1'b1; wb_ex = 1'b1; ws_eret = 1'b1; wb_excode = 5'h04;
      wb_pc = 32'h0000_0400; wb_badvaddr = 32'h0000_7777;
      we_i = 1'b1; addr_i = 8'h70; wdata_i = 32'h0000_FFFF;
      tick();
      wb_ex = 1'b0; ws_eret = 1'b0; we_i = 1'b0;
      chk("rst2_status", cp0_status, 32'h0040_0000);
      chk("rst2_cause", cp0_cause, 32'h0);
      chk("rst2_epc", cp0_epc, 32'h0);
      chk("rst2_int_req", 32'(int_req), 32'h0);
      chk("rst2_int_req1", 32'(int_req1), 32'h0);
      rd_chk("rst2_count", 8'h48, 32'h0);
      rd_chk("rst2_compare", 8'h58, 32'hFFFF_FFFF);
      rd_chk("rst2_badva", 8'h40, 32'h0);
      reset = 1'b0;
      ext_int_in = 6'd0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
